// File: rtl/fp_div_iterative_if.sv
// Start/done handshake bundle for the iterative single-precision divider.
// The master drives the request and operands; the slave returns status and the quotient.
interface fp_div_if #(
    parameter int unsigned DataSize = 32
) ();
    logic                start;
    logic [DataSize-1:0] operand1;
    logic [DataSize-1:0] operand2;
    logic                busy;
    logic                done;
    logic [DataSize-1:0] result;
    logic                div_by_zero;

    modport master (
        output start,
        output operand1,
        output operand2,
        input  busy,
        input  done,
        input  result,
        input  div_by_zero
    );

    modport slave (
        input  start,
        input  operand1,
        input  operand2,
        output busy,
        output done,
        output result,
        output div_by_zero
    );
endinterface

// File: rtl/fp_div_iterative.sv
// Multi-cycle radix-2 restoring divider for IEEE-754 single precision, with a fixed
// 27-edge latency, round-to-nearest-even and flush-to-zero of denormals.
module fp_div_iterative #(
    parameter int unsigned DataSize     = 32,
    parameter int unsigned FractionSize = 23,
    parameter int unsigned ExponentSize = 8,
    parameter int unsigned QuotBits     = 26
) (
    input logic     clk_i,
    input logic     rst_ni,
    fp_div_if.slave bus_io
);

    localparam int unsigned MantBits = FractionSize + 1;
    localparam int unsigned RemBits  = MantBits + 1;
    localparam int unsigned ExpWidth = ExponentSize + 2;
    localparam int unsigned CntBits  = $clog2(QuotBits);
    localparam int          Bias     = (2 ** (ExponentSize - 1)) - 1;

    localparam logic [ExponentSize-1:0]    ExpMax  = '1;
    localparam logic signed [ExpWidth-1:0] ExpOvf  = ExpWidth'((2 ** ExponentSize) - 1);
    localparam logic signed [ExpWidth-1:0] ExpZero = '0;

    typedef enum logic [1:0] {StIdle, StDivide, StRound} state_e;
    typedef enum logic [2:0] {SpNone, SpNan, SpDbz, SpInf, SpZero} special_e;

    state_e                      state_q;
    special_e                    spec_q;
    logic                        busy_q;
    logic                        done_q;
    logic                        dbz_q;
    logic [DataSize-1:0]         result_q;
    logic                        sign_q;
    logic signed [ExpWidth-1:0]  exp_q;
    logic [MantBits-1:0]         mb_q;
    logic [RemBits-1:0]          rem_q;
    logic [QuotBits-1:0]         quo_q;
    logic [CntBits-1:0]          cnt_q;

    // Operand decode, evaluated every cycle but only captured on the accepting edge.
    logic                        s_a, s_b;
    logic [ExponentSize-1:0]     e_a, e_b;
    logic [FractionSize-1:0]     f_a, f_b;
    logic                        a_zero, a_inf, a_nan;
    logic                        b_zero, b_inf, b_nan;
    special_e                    spec_d;
    logic [MantBits-1:0]         ma_init;
    logic [MantBits-1:0]         mb_init;
    logic signed [ExpWidth-1:0]  exp_init;

    assign {s_a, e_a, f_a} = bus_io.operand1;
    assign {s_b, e_b, f_b} = bus_io.operand2;

    always_comb begin
        a_zero   = (e_a == '0);
        a_inf    = (e_a == ExpMax) && (f_a == '0);
        a_nan    = (e_a == ExpMax) && (f_a != '0);
        b_zero   = (e_b == '0);
        b_inf    = (e_b == ExpMax) && (f_b == '0);
        b_nan    = (e_b == ExpMax) && (f_b != '0);
        ma_init  = a_zero ? '0 : {1'b1, f_a};
        mb_init  = b_zero ? '0 : {1'b1, f_b};
        exp_init = {2'b00, e_a} - {2'b00, e_b} + ExpWidth'(Bias - 1);
        spec_d   = SpNone;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_d = SpNan;
        end else if (b_zero && !a_zero && !a_inf) begin
            spec_d = SpDbz;
        end else if (a_inf) begin
            spec_d = SpInf;
        end else if (a_zero || b_inf) begin
            spec_d = SpZero;
        end
    end

    // One restoring step: R < 2*Mb holds throughout, so R fits in RemBits.
    logic               q_bit;
    logic [RemBits-1:0] rem_sub;
    logic [RemBits-1:0] rem_next;

    always_comb begin
        q_bit    = (rem_q >= {1'b0, mb_q});
        rem_sub  = rem_q - {1'b0, mb_q};
        rem_next = (q_bit ? rem_sub : rem_q) << 1;
    end

    // Normalisation, rounding and range handling of the finished quotient.
    logic                        rem_nz;
    logic [MantBits-1:0]         mant;
    logic                        guard_bit;
    logic                        sticky_bit;
    logic                        round_up;
    logic [MantBits:0]           mant_inc;
    logic signed [ExpWidth-1:0]  exp_n;
    logic signed [ExpWidth-1:0]  exp_r;
    logic [FractionSize-1:0]     frac_r;
    logic [DataSize-1:0]         norm_res;
    logic [DataSize-1:0]         final_res;

    always_comb begin
        rem_nz = (rem_q != '0);
        if (quo_q[QuotBits-1]) begin
            mant       = quo_q[QuotBits-1 -: MantBits];
            guard_bit  = quo_q[1];
            sticky_bit = quo_q[0] | rem_nz;
            exp_n      = exp_q + ExpWidth'(1);
        end else begin
            mant       = quo_q[QuotBits-2 -: MantBits];
            guard_bit  = quo_q[0];
            sticky_bit = rem_nz;
            exp_n      = exp_q;
        end
        round_up = guard_bit & (sticky_bit | mant[0]);
        mant_inc = {1'b0, mant} + {{MantBits{1'b0}}, round_up};
        exp_r    = exp_n;
        frac_r   = mant_inc[FractionSize-1:0];
        if (mant_inc[MantBits]) begin
            exp_r  = exp_n + ExpWidth'(1);
            frac_r = '0;
        end
        if (exp_r >= ExpOvf) begin
            norm_res = {sign_q, ExpMax, {FractionSize{1'b0}}};
        end else if (exp_r <= ExpZero) begin
            norm_res = {sign_q, {(DataSize-1){1'b0}}};
        end else begin
            norm_res = {sign_q, exp_r[ExponentSize-1:0], frac_r};
        end

        case (spec_q)
            SpNan:         final_res = {1'b0, ExpMax, 1'b1, {(FractionSize-1){1'b0}}};
            SpDbz, SpInf:  final_res = {sign_q, ExpMax, {FractionSize{1'b0}}};
            SpZero:        final_res = {sign_q, {(DataSize-1){1'b0}}};
            default:       final_res = norm_res;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            spec_q   <= SpNone;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            result_q <= '0;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            mb_q     <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus_io.start) begin
                        state_q <= StDivide;
                        busy_q  <= 1'b1;
                        cnt_q   <= CntBits'(QuotBits - 1);
                        spec_q  <= spec_d;
                        sign_q  <= s_a ^ s_b;
                        exp_q   <= exp_init;
                        mb_q    <= mb_init;
                        rem_q   <= {1'b0, ma_init};
                        quo_q   <= '0;
                    end
                end
                StDivide: begin
                    rem_q <= rem_next;
                    quo_q <= {quo_q[QuotBits-2:0], q_bit};
                    cnt_q <= cnt_q - CntBits'(1);
                    if (cnt_q == '0) begin
                        state_q <= StRound;
                    end
                end
                StRound: begin
                    state_q  <= StIdle;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    result_q <= final_res;
                    dbz_q    <= (spec_q == SpDbz);
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus_io.busy        = busy_q;
    assign bus_io.done        = done_q;
    assign bus_io.result      = result_q;
    assign bus_io.div_by_zero = dbz_q;

endmodule

// File: tb/tb_fp_div_iterative.sv
// Scoreboard bench for fp_div_iterative: stimulus pushes expected results and done times,
// an independent monitor pops and compares whenever Done pulses.
module tb_fp_div_iterative;

    typedef struct {
        logic [31:0] res;
        logic        dbz;
        int          done_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    fp_div_if bus ();

    fp_div_iterative dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus_io (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference quotient computed with plain integer division of the mantissas.
    function automatic logic [32:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        logic s, a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, g, st;
        int ea, eb, e;
        longint unsigned ma, mb, num, q, r, mant;
        s      = a[31] ^ b[31];
        ea     = int'(a[30:23]);
        eb     = int'(b[30:23]);
        a_zero = (ea == 0);
        a_inf  = (ea == 255) && (a[22:0] == 0);
        a_nan  = (ea == 255) && (a[22:0] != 0);
        b_zero = (eb == 0);
        b_inf  = (eb == 255) && (b[22:0] == 0);
        b_nan  = (eb == 255) && (b[22:0] != 0);
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) return {1'b0, 32'h7FC00000};
        if (b_zero && !a_zero && !a_inf) return {1'b1, s, 8'hFF, 23'h0};
        if (a_inf) return {1'b0, s, 8'hFF, 23'h0};
        if (a_zero || b_inf) return {1'b0, s, 31'h0};
        ma  = 64'h800000 | 64'(a[22:0]);
        mb  = 64'h800000 | 64'(b[22:0]);
        num = ma << 25;
        q   = num / mb;
        r   = num % mb;
        if (q >= (64'd1 << 25)) begin
            mant = q >> 2;
            g    = q[1];
            st   = q[0] | (r != 0);
            e    = ea - eb + 127;
        end else begin
            mant = q >> 1;
            g    = q[0];
            st   = (r != 0);
            e    = ea - eb + 126;
        end
        if (g && (st || mant[0])) mant = mant + 1;
        if (mant == (64'd1 << 24)) begin
            mant = 64'd1 << 23;
            e    = e + 1;
        end
        if (e >= 255) return {1'b0, s, 8'hFF, 23'h0};
        if (e <= 0) return {1'b0, s, 31'h0};
        return {1'b0, s, e[7:0], mant[22:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        int          k = $urandom_range(0, 11);
        logic        s = 1'($urandom());
        logic [22:0] f = 23'($urandom());
        logic [7:0]  e = 8'($urandom_range(1, 254));
        case (k)
            0:       return {s, 31'h0};
            1:       return {s, 8'hFF, 23'h0};
            2:       return {s, 8'hFF, f | 23'h1};
            3:       return {s, 8'h00, f};
            4:       return {s, e, 23'h0};
            5:       return {s, 8'($urandom_range(1, 3)), f};
            6:       return {s, 8'($urandom_range(250, 254)), f};
            default: return {s, e, f};
        endcase
    endfunction

    // Monitor: every Done must match the oldest outstanding expectation, on time.
    always @(negedge clk) begin
        exp_t e;
        if (bus.done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_done actual=1 required=0 (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                check("result", bus.result, e.res);
                check("div_by_zero", 32'(bus.div_by_zero), 32'(e.dbz));
                check("done_latency", 32'(cyc), 32'(e.done_cyc));
            end
        end
    end

    // Drives a one-cycle Start; returns at the negedge after the accepting edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic dbz);
        exp_t e;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.operand1 = a;
        bus.operand2 = b;
        e.res        = res;
        e.dbz        = dbz;
        e.done_cyc   = cyc + 28;
        sb.push_back(e);
        @(negedge clk);
        bus.start    = 1'b0;
        bus.operand1 = $urandom();
        bus.operand2 = $urandom();
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 80) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout actual=%0d pending required=0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input logic dbz, input string name);
        issue(a, b, res, dbz);
        wait_idle(name);
    endtask

    task automatic check_quiet(input string name);
        check({name, "_busy"}, 32'(bus.busy), 32'h0);
        check({name, "_done"}, 32'(bus.done), 32'h0);
        check({name, "_result"}, bus.result, 32'h0);
        check({name, "_dbz"}, 32'(bus.div_by_zero), 32'h0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a, b;
        logic [32:0] r;
        int          bc;

        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.operand1 = '0;
        bus.operand2 = '0;
        repeat (3) @(negedge clk);
        check_quiet("reset");
        rst_n = 1'b1;

        // 6.0 / 2.0 with a busy-width measurement
        issue(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);
        bc = 0;
        for (int i = 0; i < 40 && !bus.done; i++) begin
            if (bus.busy) bc++;
            @(negedge clk);
        end
        check("busy_cycles", 32'(bc), 32'd27);
        check("busy_at_done", 32'(bus.busy), 32'h0);
        wait_idle("six_by_two");

        run_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, "one_third");
        run_op(32'hC0F00000, 32'h40200000, 32'hC0400000, 1'b0, "neg_div");
        run_op(32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, "div_zero");
        run_op(32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0, "zero_zero");
        run_op(32'h7F7FFFFF, 32'h00800000, 32'h7F800000, 1'b0, "overflow");
        run_op(32'h00800000, 32'h40000000, 32'h00000000, 1'b0, "underflow");
        run_op(32'h7F800000, 32'h7F800000, 32'h7FC00000, 1'b0, "inf_inf");
        run_op(32'hFF800000, 32'h00000000, 32'hFF800000, 1'b0, "inf_zero");
        run_op(32'h40000000, 32'hFF800000, 32'h80000000, 1'b0, "fin_inf");

        // Start held through Busy with changing operands; second op accepted at Done
        @(negedge clk);
        bus.start    = 1'b1;
        bus.operand1 = 32'h40C00000;
        bus.operand2 = 32'h40000000;
        sb.push_back('{res: 32'h40400000, dbz: 1'b0, done_cyc: cyc + 28});
        @(negedge clk);
        bus.operand1 = 32'h3F800000;
        bus.operand2 = 32'h40400000;
        repeat (27) @(negedge clk);
        sb.push_back('{res: 32'h3EAAAAAB, dbz: 1'b0, done_cyc: cyc + 28});
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle("held_start");

        // Reset at DIVIDE iteration 10 aborts without a Done
        issue(32'h40C00000, 32'h40400000, 32'h40000000, 1'b0);
        repeat (10) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_quiet("mid_reset");
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        run_op(32'hC0F00000, 32'h40200000, 32'hC0400000, 1'b0, "after_reset");

        for (int i = 0; i < 300; i++) begin
            a = rand_op();
            b = rand_op();
            r = ref_div(a, b);
            run_op(a, b, r[31:0], r[32], "random");
        end

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
